// File: rtl/perceptron_feeder.sv
`timescale 1ns/1ps
// Buffers a frame of samples, then streams one (sample, weight, bias) triple per clock to the perceptron.
// Optional double-buffered sample store: define PERCEPTRON_FEEDER_PINGPONG_EN.
module perceptron_feeder #(
  parameter int FRAME_LEN = 16,
  parameter int DATA_W    = 8,
  parameter int IDX_W     = $clog2(FRAME_LEN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [DATA_W-1:0] s_data,
  input  logic                     cfg_we,
  input  logic [IDX_W-1:0]         cfg_addr,
  input  logic signed [DATA_W-1:0] cfg_weight,
  input  logic signed [DATA_W-1:0] cfg_bias,
  output logic signed [DATA_W-1:0] input_signal,
  output logic signed [DATA_W-1:0] weight,
  output logic signed [DATA_W-1:0] bias,
  output logic                     issue_valid,
  output logic [IDX_W-1:0]         issue_idx,
  output logic                     frame_done,
  output logic                     busy
);

  typedef enum logic {FILL, ISSUE} state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(FRAME_LEN - 1);

  state_t state, state_nxt;
  logic [IDX_W-1:0] cnt;
  logic ready_q, ready_nxt;
  logic hs, fill_last, last_tap, start;

  logic signed [DATA_W-1:0] sbuf [2][FRAME_LEN];
  logic signed [DATA_W-1:0] wtab [FRAME_LEN];
  logic signed [DATA_W-1:0] btab [FRAME_LEN];

`ifdef PERCEPTRON_FEEDER_PINGPONG_EN
  logic full, full_nxt;
  logic fill_bank, rd_bank;
`else
  localparam logic fill_bank = 1'b0;
  localparam logic rd_bank   = 1'b0;
`endif

  assign s_ready   = ready_q;
  assign hs        = s_valid & ready_q;
  assign fill_last = hs && (cnt == LAST);
  assign last_tap  = (issue_idx == LAST);
  assign busy      = (state == ISSUE);

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
`ifdef PERCEPTRON_FEEDER_PINGPONG_EN
    full_nxt  = full;
    case (state)
      // A bank that filled during ISSUE waits out the frame_done cycle before swapping.
      FILL: begin
        start = (full && !frame_done) || fill_last;
        if (start) begin
          state_nxt = ISSUE;
          full_nxt  = 1'b0;
        end
      end
      ISSUE: begin
        if (fill_last) full_nxt = 1'b1;
        if (last_tap) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
    ready_nxt = !full_nxt;
`else
    case (state)
      FILL: begin
        start = fill_last;
        if (start) state_nxt = ISSUE;
      end
      ISSUE: if (last_tap) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
    ready_nxt = (state_nxt == FILL);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FILL;
      ready_q <= 1'b0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      ready_q <= ready_nxt;
      if (hs) cnt <= cnt + 1'b1;  // FRAME_LEN is a power of two, so this wraps to 0
    end
  end

`ifdef PERCEPTRON_FEEDER_PINGPONG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full      <= 1'b0;
      fill_bank <= 1'b0;
      rd_bank   <= 1'b0;
    end else begin
      full <= full_nxt;
      if (start) begin
        rd_bank   <= fill_bank;
        fill_bank <= ~fill_bank;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (hs) sbuf[fill_bank][cnt] <= s_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < FRAME_LEN; k++) begin
        wtab[k] <= '0;
        btab[k] <= '0;
      end
    end else if (cfg_we) begin
      wtab[cfg_addr] <= cfg_weight;
      btab[cfg_addr] <= cfg_bias;
    end
  end

  // Tap 0 is loaded on the edge that enters ISSUE; table reads see pre-write contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      input_signal <= '0;
      weight       <= '0;
      bias         <= '0;
      issue_valid  <= 1'b0;
      issue_idx    <= '0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= (state == ISSUE) && last_tap;
      if (start) begin
        input_signal <= sbuf[fill_bank][0];
        weight       <= wtab[0];
        bias         <= btab[0];
        issue_valid  <= 1'b1;
        issue_idx    <= '0;
      end else if ((state == ISSUE) && !last_tap) begin
        input_signal <= sbuf[rd_bank][issue_idx + 1'b1];
        weight       <= wtab[issue_idx + 1'b1];
        bias         <= btab[issue_idx + 1'b1];
        issue_valid  <= 1'b1;
        issue_idx    <= issue_idx + 1'b1;
      end else begin
        input_signal <= '0;
        weight       <= '0;
        bias         <= '0;
        issue_valid  <= 1'b0;
        issue_idx    <= '0;
      end
    end
  end

endmodule

// File: doc/perceptron_feeder.md
Name: perceptron_feeder

Overview:
- Upstream stage of the perceptron neuron.
- Collects a frame of FRAME_LEN signed 8-bit audio samples over a valid/ready stream.
- Then issues one (sample, weight, bias) triple per clock to the perceptron's input_signal/weight/bias inputs, from a locally stored per-tap weight/bias table.
- Produces an issue strobe and a frame_done strobe aligned to the perceptron's 1-cycle output latency, so the downstream collector knows when each output_signal is valid.

Parameters:
- FRAME_LEN, 16, samples per frame; power of two, 2..64.
- DATA_W, 8, sample/weight/bias width (signed).
- IDX_W, $clog2(FRAME_LEN), tap index width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  feeder can accept a sample.
- s_data  in  DATA_W  signed audio sample.
- cfg_we  in  1  weight/bias table write enable.
- cfg_addr  in  IDX_W  table entry to write.
- cfg_weight  in  DATA_W  signed weight for cfg_addr.
- cfg_bias  in  DATA_W  signed bias for cfg_addr.
- input_signal  out  DATA_W  sample to perceptron (registered).
- weight  out  DATA_W  weight to perceptron (registered).
- bias  out  DATA_W  bias to perceptron (registered).
- issue_valid  out  1  current triple is a real issue.
- issue_idx  out  IDX_W  tap index of current triple.
- frame_done  out  1  one-cycle pulse, cycle after last issue.
- busy  out  1  high in ISSUE state.

Behaviour:
- Reset (async, rst=1): state=FILL, fill count=0, issue index=0, all table entries=0, and every output low/zero. s_ready goes low during reset and rises on the first clk edge after rst deasserts. Sample buffer contents are don't-care.
- FILL state:
  - s_ready=1.
  - Each cycle with s_valid&&s_ready writes s_data to buf[count] and increments count.
  - When the FRAME_LEN-th sample is accepted (count==FRAME_LEN-1 and handshake): count returns to 0 and next state=ISSUE.
- ISSUE state (non-pingpong build):
  - s_ready=0, busy=1.
  - For i=0..FRAME_LEN-1, one per cycle with no gaps: input_signal=buf[i], weight=W[i], bias=B[i], issue_idx=i, issue_valid=1.
  - Outputs are registered, so the first triple appears the cycle after entering ISSUE.
  - After index FRAME_LEN-1 is presented, state returns to FILL. issue_valid=0 and frame_done=1 for exactly one cycle, which coincides with the perceptron's output for tap FRAME_LEN-1.
- Per-frame latency: last sample accepted at cycle T → issue i at T+1+i → frame_done at T+1+FRAME_LEN.
- Idle outputs: when issue_valid=0, input_signal/weight/bias hold 0, so the perceptron output is ReLU(0)=0.
- Config writes:
  - Accepted in any state.
  - The table is written at the clock edge.
  - A write to the entry being read in the same cycle issues the OLD value (read-before-write).
- s_valid while s_ready=0: sample is not consumed. The source must hold it (standard valid/ready).
- No arithmetic is performed; values pass bit-exact and signed.
- Reset mid-frame or mid-issue: the frame is abandoned, no frame_done is produced, and the table is cleared to 0.

Optional Feature:
- Macro: PERCEPTRON_FEEDER_PINGPONG_EN.
- Defined:
  - Two sample banks. The fill bank accepts samples while the issue engine drains the other, so s_ready stays 1 during ISSUE unless the fill bank is full.
  - A full fill bank waits (s_ready=0) until the issue engine finishes, then banks swap. ISSUE restarts the cycle after frame_done, giving back-to-back frames with a 1-cycle gap.
  - busy covers ISSUE only.
- Undefined: single bank, behaviour as above, s_ready=0 throughout ISSUE.

Test Plan:
- Reset then table load W[i]=i+1, B[i]=-i, then stream samples 10..25 (FRAME_LEN=16) → issue i shows input_signal=10+i, weight=i+1, bias=-i, with issue_idx 0..15 contiguous; frame_done at T+17; perceptron output at tap 3 = 13*4-3=49.
- Negative values: s_data=-128 at tap 0, W[0]=1 → input_signal=8'h80 passes unaltered; no sign loss.
- Backpressure: s_valid held 1 through ISSUE (non-pingpong) → s_ready=0 for 16 cycles, no sample lost or duplicated; next frame's first sample = the value held.
- Config write to addr 5 (W=7) in the same cycle tap 5 issues with old W=6 → weight=6 issued; next frame issues 7.
- rst pulse at issue index 8 → all outputs 0 asynchronously; no frame_done; next 16 accepted samples form a fresh frame; table is all zero.
- PINGPONG_EN: continuous s_valid=1 → 16 accepted samples during each ISSUE; frames issue with exactly 1 idle cycle between frame_done and the next issue_valid.
